// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit - RV32 fetch stage: PC, req/gnt fetch, PC tag queue and an
// instruction FIFO to the decoder. Optional macro: ILLEGAL_OPCODE_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
`ifdef ILLEGAL_OPCODE_FILTER_EN
    output logic        if_illegal,
`endif
    output logic [31:0] if_pc
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   discard_q, discard_d;

    logic [31:0]        tag_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   tag_wr_q, tag_rd_q;

    logic [31:0]        instr_mem_q [FIFO_DEPTH];
    logic [31:0]        pcm_mem_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]   fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0]   fifo_rd_q, fifo_rd_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_outst_after_resp;
    logic [31:0]        w_push_instr;

    // Slots are reserved at request time, so responses can always be absorbed.
    assign imem_req  = reset && (state_q == ST_FETCH) && !redirect &&
                       (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_EXT);
    assign imem_addr = pc_q;

    assign w_issue = imem_req && imem_gnt;
    assign w_push  = imem_rvalid && (discard_q == '0) && !redirect;
    assign w_pop   = if_valid && if_ready && !redirect;
    assign w_outst_after_resp = outst_q - CNT_W'(imem_rvalid);

`ifdef ILLEGAL_OPCODE_FILTER_EN
    logic w_legal;
    logic ill_mem_q [FIFO_DEPTH];

    always_comb begin
        w_legal = 1'b0;
        case (imem_rdata[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b1101111: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    assign w_push_instr = w_legal ? imem_rdata : NOP;
    assign if_illegal   = if_valid && ill_mem_q[fifo_rd_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) ill_mem_q[i] <= 1'b0;
        end else if (w_push) begin
            ill_mem_q[fifo_wr_q] <= !w_legal;
        end
    end
`else
    assign w_push_instr = imem_rdata;
`endif

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q + CNT_W'(w_issue) - CNT_W'(imem_rvalid);
        discard_d = discard_q;
        state_d   = state_q;

        if (redirect) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (w_issue) begin
            pc_d = pc_q + 32'd4;
        end

        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    discard_d = w_outst_after_resp;
                    state_d   = (w_outst_after_resp != '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // A redirect here only retargets pc; the discard count stands.
                if (discard_d == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (redirect) begin
            fifo_rd_d  = fifo_wr_q;
            fifo_cnt_d = '0;
        end else begin
            if (w_push) fifo_wr_d = fifo_wr_q + PTR_W'(1);
            if (w_pop)  fifo_rd_d = fifo_rd_q + PTR_W'(1);
            fifo_cnt_d = fifo_cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_q[i]   <= '0;
                instr_mem_q[i] <= NOP;
                pcm_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (w_issue) begin
                tag_mem_q[tag_wr_q] <= pc_q;
                tag_wr_q            <= tag_wr_q + PTR_W'(1);
            end
            // Tags are popped for every response, kept or discarded.
            if (imem_rvalid) begin
                tag_rd_q <= tag_rd_q + PTR_W'(1);
            end
            if (w_push) begin
                instr_mem_q[fifo_wr_q] <= w_push_instr;
                pcm_mem_q[fifo_wr_q]   <= tag_mem_q[tag_rd_q];
            end
        end
    end

    assign if_valid       = (fifo_cnt_q != '0);
    assign if_instruction = if_valid ? instr_mem_q[fifo_rd_q] : NOP;
    assign if_pc          = if_valid ? pcm_mem_q[fifo_rd_q]   : 32'h0;

endmodule

`default_nettype wire
